// File: rtl/module_control_correccion.sv
// Sequencing controller for the Hamming (7,4) receive path.
// Accepts a received codeword, presents it to the external syndrome detector,
// corrects the single flagged bit and delivers the corrected word and data.
// Also keeps saturating statistics of delivered and corrected words.
module module_control_correccion #(
  parameter int ANCHO_CNT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Receive handshake
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_palabra,
  // External syndrome detector
  output logic [6:0]           det_palabra,
  input  logic [2:0]           det_sindrome,
  // Delivery handshake
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [6:0]           out_palabra,
  output logic [3:0]           out_datos,
  output logic                 out_corregido,
  output logic [2:0]           out_sindrome,
  // Statistics
  input  logic                 clr_cnt,
  output logic [ANCHO_CNT-1:0] cnt_palabras,
  output logic [ANCHO_CNT-1:0] cnt_errores
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVALUA  = 2'd1,
    CORRIGE = 2'd2,
    SALIDA  = 2'd3
  } estado_t;

  localparam logic [ANCHO_CNT-1:0] CNT_MAX = '1;
  localparam logic [ANCHO_CNT-1:0] CNT_UNO = {{(ANCHO_CNT-1){1'b0}}, 1'b1};

  estado_t              estado_q, estado_d;
  logic [6:0]           palabra_q;       // word under evaluation
  logic [6:0]           palabra_corr;    // word with the flagged bit inverted
  logic [2:0]           sindrome_q;      // syndrome sampled at the end of EVALUA
  logic [6:0]           out_palabra_q;
  logic [2:0]           out_sindrome_q;
  logic                 out_corregido_q;
  logic [ANCHO_CNT-1:0] cnt_palabras_q;
  logic [ANCHO_CNT-1:0] cnt_errores_q;
  logic                 acepta;
  logic                 entrega;

  assign acepta  = in_valid  & in_ready;
  assign entrega = out_valid & out_ready;

  // Next-state and handshake outputs of the sequencing FSM.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave it unassigned (no latch).
    estado_d  = estado_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (estado_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) estado_d = EVALUA;
      end
      EVALUA:  estado_d = CORRIGE;
      CORRIGE: estado_d = SALIDA;
      SALIDA: begin
        out_valid = 1'b1;
        if (out_ready) estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  // State register; reset discards any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs from before the edge.
    if (!rst_n) estado_q <= IDLE;
    else        estado_q <= estado_d;
  end

  // Single-bit corrector: syndrome s (1..7) names bit s-1; zero leaves the word.
  always_comb begin
    palabra_corr = palabra_q;
    for (int i = 0; i < 7; i++) begin
      if (sindrome_q == 3'(i + 1)) palabra_corr[i] = ~palabra_q[i];
    end
  end

  // Datapath registers: capture word, capture syndrome, correct and publish.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath register is reset, because the output values after
    // reset are defined as zero rather than left to power-up contents.
    if (!rst_n) begin
      palabra_q       <= '0;
      sindrome_q      <= '0;
      out_palabra_q   <= '0;
      out_sindrome_q  <= '0;
      out_corregido_q <= 1'b0;
    end else begin
      if (acepta) palabra_q <= in_palabra;
      if (estado_q == EVALUA) sindrome_q <= det_sindrome;
      if (estado_q == CORRIGE) begin
        palabra_q       <= palabra_corr;
        out_palabra_q   <= palabra_corr;
        out_sindrome_q  <= sindrome_q;
        out_corregido_q <= |sindrome_q;
      end
    end
  end

  // Saturating statistics; a clear on the same edge as a delivery wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_palabras_q <= '0;
      cnt_errores_q  <= '0;
    end else if (clr_cnt) begin
      cnt_palabras_q <= '0;
      cnt_errores_q  <= '0;
    end else if (entrega) begin
      if (cnt_palabras_q != CNT_MAX) cnt_palabras_q <= cnt_palabras_q + CNT_UNO;
      if (out_corregido_q && (cnt_errores_q != CNT_MAX))
        cnt_errores_q <= cnt_errores_q + CNT_UNO;
    end
  end

  assign det_palabra   = palabra_q;
  assign out_palabra   = out_palabra_q;
  assign out_datos     = {out_palabra_q[6], out_palabra_q[5], out_palabra_q[4], out_palabra_q[2]};
  assign out_sindrome  = out_sindrome_q;
  assign out_corregido = out_corregido_q;
  assign cnt_palabras  = cnt_palabras_q;
  assign cnt_errores   = cnt_errores_q;

endmodule

// File: tb/tb_module_control_correccion.sv
// Self-checking bench for module_control_correccion. A behavioural Hamming
// (7,4) detector drives det_sindrome; expected results come from the
// positional definition of the code. A second instance with 2-bit counters
// shares all inputs to observe counter saturation.
module tb_module_control_correccion;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] in_palabra;
  logic       out_ready;
  logic       clr_cnt;

  logic       in_ready, out_valid, out_corregido;
  logic [6:0] det_palabra, out_palabra;
  logic [2:0] det_sindrome, out_sindrome;
  logic [3:0] out_datos;
  logic [7:0] cnt_palabras, cnt_errores;

  logic       in_ready_b, out_valid_b, out_corregido_b;
  logic [6:0] det_palabra_b, out_palabra_b;
  logic [2:0] det_sindrome_b, out_sindrome_b;
  logic [3:0] out_datos_b;
  logic [1:0] cnt_palabras_b, cnt_errores_b;

  int n_tests = 0;
  int n_fail  = 0;
  int m_pal   = 0;  // words delivered since last clear (unbounded)
  int m_err   = 0;  // corrected words delivered since last clear (unbounded)

  always #5 clk = ~clk;

  // Syndrome = XOR of the 1-based positions of all set bits.
  function automatic logic [2:0] sindrome_f(input logic [6:0] w);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 7; i++) if (w[i]) s ^= 3'(i + 1);
    return s;
  endfunction

  assign det_sindrome   = sindrome_f(det_palabra);
  assign det_sindrome_b = sindrome_f(det_palabra_b);

  module_control_correccion #(.ANCHO_CNT(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_palabra(in_palabra),
    .det_palabra(det_palabra), .det_sindrome(det_sindrome),
    .out_valid(out_valid), .out_ready(out_ready), .out_palabra(out_palabra),
    .out_datos(out_datos), .out_corregido(out_corregido), .out_sindrome(out_sindrome),
    .clr_cnt(clr_cnt), .cnt_palabras(cnt_palabras), .cnt_errores(cnt_errores)
  );

  module_control_correccion #(.ANCHO_CNT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_palabra(in_palabra),
    .det_palabra(det_palabra_b), .det_sindrome(det_sindrome_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_palabra(out_palabra_b),
    .out_datos(out_datos_b), .out_corregido(out_corregido_b), .out_sindrome(out_sindrome_b),
    .clr_cnt(clr_cnt), .cnt_palabras(cnt_palabras_b), .cnt_errores(cnt_errores_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Valid codeword for random data, optionally with one bit flipped.
  function automatic logic [6:0] gen_word();
    logic [3:0] d;
    logic [6:0] c;
    int         e;
    d    = 4'($urandom);
    c[6] = d[3]; c[5] = d[2]; c[4] = d[1]; c[2] = d[0];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    e    = int'($urandom_range(0, 7));
    if (e != 0) c[e-1] = ~c[e-1];
    return c;
  endfunction

  function automatic logic [6:0] corrige_f(input logic [6:0] w);
    logic [6:0] p;
    int         s;
    p = w;
    s = int'(sindrome_f(w));
    if (s != 0) p[s-1] = ~p[s-1];
    return p;
  endfunction

  task automatic check_cnt(input string tag);
    check({tag, "_cnt_pal"},   32'(cnt_palabras),   32'(sat(m_pal, 255)));
    check({tag, "_cnt_err"},   32'(cnt_errores),    32'(sat(m_err, 255)));
    check({tag, "_cnt_pal_b"}, 32'(cnt_palabras_b), 32'(sat(m_pal, 3)));
    check({tag, "_cnt_err_b"}, 32'(cnt_errores_b),  32'(sat(m_err, 3)));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // One word: accept, check latency, optional back-pressure, deliver.
  task automatic run_word(input logic [6:0] w, input int hold, input bit clr);
    logic [6:0] ep;
    logic [2:0] es;
    es = sindrome_f(w);
    ep = corrige_f(w);
    wait_ready();
    in_palabra = w;
    in_valid   = 1'b1;
    out_ready  = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_in_ready", 32'(in_ready), 32'd0);
    check("lat_edge1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge3", 32'(out_valid), 32'd1);
    check("out_palabra", 32'(out_palabra), 32'(ep));
    check("out_datos", 32'(out_datos), 32'({ep[6], ep[5], ep[4], ep[2]}));
    check("out_sindrome", 32'(out_sindrome), 32'(es));
    check("out_corregido", 32'(out_corregido), 32'(es != 3'd0));
    for (int i = 0; i < hold; i++) begin
      in_valid   = 1'b1;        // a competing word must not be consumed
      in_palabra = ~w;
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_palabra", 32'(out_palabra), 32'(ep));
      check("hold_sindrome", 32'(out_sindrome), 32'(es));
    end
    out_ready = 1'b1;
    clr_cnt   = clr;
    @(posedge clk); #1;
    clr_cnt  = 1'b0;
    in_valid = 1'b0;
    if (clr) begin
      m_pal = 0;
      m_err = 0;
    end else begin
      m_pal++;
      if (es != 3'd0) m_err++;
    end
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check_cnt("post");
  endtask

  logic [6:0] sw [8];
  logic [6:0] exp_q [$];
  logic       err_q [$];
  logic       prev_v, was_ready, e_flag;
  logic [6:0] prev_p, e_word;
  int         acc, deliv;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_palabra = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_palabra", 32'(out_palabra), 32'd0);
    check("rst_det_palabra", 32'(det_palabra), 32'd0);
    check_cnt("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed words: valid, data-bit error, top-bit error
    run_word(7'b1111111, 0, 1'b0);
    run_word(7'b0011101, 0, 1'b0);
    run_word(7'b1000000, 0, 1'b0);
    // Back-pressure, then the competing word goes through
    run_word(7'b0000111, 5, 1'b0);
    run_word(7'b1111000, 0, 1'b0);

    // Counter sequence: clear, 3 words (last 2 corrupted), clear on delivery
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    m_pal = 0; m_err = 0;
    check_cnt("clr");
    run_word(7'b1111111, 0, 1'b0);
    run_word(7'b0011101, 0, 1'b0);
    run_word(7'b1000000, 1, 1'b0);
    check("three_words_pal", 32'(cnt_palabras), 32'd3);
    check("three_words_err", 32'(cnt_errores), 32'd2);
    run_word(7'b0110011, 0, 1'b1);
    check("clr_on_delivery", 32'(cnt_palabras), 32'd0);
    for (int i = 0; i < 5; i++) run_word(gen_word(), 0, 1'b0);
    check("sat_b_pal", 32'(cnt_palabras_b), 32'd3);
    check("nosat_pal", 32'(cnt_palabras), 32'd5);

    // Randomized words with random back-pressure
    for (int i = 0; i < 20; i++) run_word(gen_word(), int'($urandom_range(0, 2)), 1'b0);

    // Reset while a word sits in CORRIGE
    in_palabra = 7'b0011101;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    m_pal = 0; m_err = 0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_palabra", 32'(out_palabra), 32'd0);
    check("midrst_out_datos", 32'(out_datos), 32'd0);
    check("midrst_out_sindrome", 32'(out_sindrome), 32'd0);
    check("midrst_out_corregido", 32'(out_corregido), 32'd0);
    check("midrst_det_palabra", 32'(det_palabra), 32'd0);
    check_cnt("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_word(7'b1010101, 0, 1'b0);

    // Streaming: 8 words in 32 cycles with both handshakes held open
    for (int j = 0; j < 8; j++) sw[j] = gen_word();
    acc = 0; deliv = 0;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_palabra = sw[0];
    prev_v = out_valid;
    prev_p = out_palabra;
    for (int k = 1; k <= 32; k++) begin
      was_ready = in_ready;
      @(posedge clk); #1;
      if (was_ready && acc < 8) begin
        exp_q.push_back(corrige_f(sw[acc]));
        err_q.push_back(sindrome_f(sw[acc]) != 3'd0);
        acc++;
      end
      if (prev_v) begin
        deliv++;
        e_word = exp_q.pop_front();
        e_flag = err_q.pop_front();
        check("stream_word", 32'(prev_p), 32'(e_word));
        m_pal++;
        if (e_flag) m_err++;
      end
      prev_v = out_valid;
      prev_p = out_palabra;
      if (acc < 8) in_palabra = sw[acc];
      else         in_valid   = 1'b0;
    end
    check("stream_deliveries", 32'(deliv), 32'd8);
    check_cnt("stream");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
